// File: rtl/cpu_pkg.sv
// Shared constants and the writeback entry type for the CPU datapath.
// Entries carry a destination register and an 8-bit signed result.
package cpu_pkg;

    localparam int unsigned BUS_WIDTH = 7;
    localparam int unsigned MAX_REGISTERS = 16;

    function automatic int unsigned reg_addr_width_of(input int unsigned registers);
        return (registers > 1) ? $clog2(registers) : 1;
    endfunction

    localparam int unsigned REG_ADDR_WIDTH = reg_addr_width_of(MAX_REGISTERS);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] address;
        logic signed [BUS_WIDTH:0] data;
    } writeback_entry_t;

endpackage

// File: rtl/cpu_writeback_stage_if.sv
// Producer-side handshakes into the writeback stage: ALU and tensor readback channels.
// master = producers, slave = writeback stage.
interface cpu_writeback_stage_if #(
    parameter int unsigned NUMBER_OF_REGISTERS = 16
);
    import cpu_pkg::*;

    localparam int unsigned AW = reg_addr_width_of(NUMBER_OF_REGISTERS);

    logic                      alu_valid_in;
    logic                      alu_ready_out;
    logic [AW-1:0]             alu_address_in;
    logic signed [BUS_WIDTH:0] alu_data_in;
    logic                      tensor_valid_in;
    logic                      tensor_ready_out;
    logic [AW-1:0]             tensor_address_in;
    logic signed [BUS_WIDTH:0] tensor_data_in;

    modport master (
        output alu_valid_in, alu_address_in, alu_data_in,
        output tensor_valid_in, tensor_address_in, tensor_data_in,
        input  alu_ready_out, tensor_ready_out
    );

    modport slave (
        input  alu_valid_in, alu_address_in, alu_data_in,
        input  tensor_valid_in, tensor_address_in, tensor_data_in,
        output alu_ready_out, tensor_ready_out
    );

endinterface

// File: rtl/writeback_fifo.sv
// Synchronous FIFO of writeback entries for the tensor channel.
// Exposes storage and per-slot valid bits so the stage can build its pending bitmap.
module writeback_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic                          push_in,
    input  writeback_entry_t              push_entry_in,
    input  logic                          pop_in,
    output writeback_entry_t              head_entry_out,
    output logic                          full_out,
    output logic                          empty_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out,
    output writeback_entry_t              entries_out [FIFO_DEPTH],
    output logic [FIFO_DEPTH-1:0]         entry_valid_out
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    writeback_entry_t entries_q [FIFO_DEPTH];
    logic [PW-1:0]    read_pointer_q;
    logic [PW-1:0]    write_pointer_q;
    logic [CW-1:0]    count_q;
    logic             push_enable;
    logic             pop_enable;
    logic [PW-1:0]    slot_offset;

    assign full_out       = (count_q == CW'(FIFO_DEPTH));
    assign empty_out      = (count_q == '0);
    assign count_out      = count_q;
    assign push_enable    = push_in && !full_out;
    assign pop_enable     = pop_in && !empty_out;
    assign head_entry_out = entries_q[read_pointer_q];
    assign entries_out    = entries_q;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            read_pointer_q  <= '0;
            write_pointer_q <= '0;
            count_q         <= '0;
        end else begin
            if (push_enable) begin
                entries_q[write_pointer_q] <= push_entry_in;
                write_pointer_q            <= write_pointer_q + PW'(1);
            end
            if (pop_enable) begin
                read_pointer_q <= read_pointer_q + PW'(1);
            end
            if (push_enable != pop_enable) begin
                count_q <= push_enable ? count_q + CW'(1) : count_q - CW'(1);
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_valid_out = '0;
        slot_offset     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_offset        = PW'(i) - read_pointer_q;
            entry_valid_out[i] = ({1'b0, slot_offset} < count_q);
        end
    end

endmodule

// File: rtl/cpu_writeback_stage.sv
// Writeback stage: arbitrates ALU and buffered tensor results onto the single
// register-file write port, with starvation control and a pending-write bitmap.
module cpu_writeback_stage
    import cpu_pkg::*;
#(
    parameter int unsigned NUMBER_OF_REGISTERS = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT = 3,
    localparam int unsigned AW = reg_addr_width_of(NUMBER_OF_REGISTERS)
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    cpu_writeback_stage_if.slave           bus,
    output logic                           write_enable_out,
    output logic [AW-1:0]                  write_register_address_out,
    output logic signed [BUS_WIDTH:0]      write_data_out,
    output logic [NUMBER_OF_REGISTERS-1:0] pending_out,
    output logic [7:0]                     dropped_count_out
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    writeback_entry_t          alu_entry;
    writeback_entry_t          tensor_entry;
    writeback_entry_t          head_entry;
    writeback_entry_t          selected_entry;
    writeback_entry_t          fifo_entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     fifo_entry_valid;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      take_alu;
    logic                      selected_valid;
    logic                      starved;
    logic [SW-1:0]             starve_q;
    logic [SW-1:0]             starve_d;
    logic                      write_enable_q;
    logic [AW-1:0]             write_address_q;
    logic signed [BUS_WIDTH:0] write_data_q;
    logic [7:0]                dropped_q;
    logic [NUMBER_OF_REGISTERS-1:0] pending;

    assign alu_entry    = '{address: REG_ADDR_WIDTH'(bus.alu_address_in),
                            data: bus.alu_data_in};
    assign tensor_entry = '{address: REG_ADDR_WIDTH'(bus.tensor_address_in),
                            data: bus.tensor_data_in};

    assign bus.tensor_ready_out = (fifo_count < CW'(FIFO_DEPTH));
    assign fifo_push            = bus.tensor_valid_in && bus.tensor_ready_out;

    writeback_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .push_in         (fifo_push),
        .push_entry_in   (tensor_entry),
        .pop_in          (fifo_pop),
        .head_entry_out  (head_entry),
        .full_out        (fifo_full),
        .empty_out       (fifo_empty),
        .count_out       (fifo_count),
        .entries_out     (fifo_entries),
        .entry_valid_out (fifo_entry_valid)
    );

    always_comb begin
        starved           = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
        bus.alu_ready_out = 1'b1;
        take_alu          = 1'b0;
        fifo_pop          = 1'b0;
        if (fifo_full || starved) begin
            fifo_pop          = 1'b1;
            bus.alu_ready_out = 1'b0;
        end else if (bus.alu_valid_in) begin
            take_alu = 1'b1;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
        end
        selected_valid = take_alu || fifo_pop;
        selected_entry = take_alu ? alu_entry : head_entry;

        // Counts ALU wins only while tensor entries are waiting behind them.
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (take_alu) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            starve_q        <= '0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            dropped_q       <= '0;
        end else begin
            starve_q       <= starve_d;
            write_enable_q <= 1'b0;
            if (selected_valid) begin
                // Register 0 is hardwired: consume the entry but never write it.
                if (selected_entry.address == '0) begin
                    if (dropped_q != 8'hFF) begin
                        dropped_q <= dropped_q + 8'd1;
                    end
                end else begin
                    write_enable_q  <= 1'b1;
                    write_address_q <= AW'(selected_entry.address);
                    write_data_q    <= selected_entry.data;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_entry_valid[i]) begin
                pending[AW'(fifo_entries[i].address)] = 1'b1;
            end
        end
        if (write_enable_q) begin
            pending[write_address_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign write_enable_out           = write_enable_q;
    assign write_register_address_out = write_address_q;
    assign write_data_out             = write_data_q;
    assign pending_out                = pending;
    assign dropped_count_out          = dropped_q;

endmodule
